// File: rtl/bram_port_pkg.sv
// Shared definitions for the BRAM port requester: latency encodings,
// parameter-legality helpers and request/response record layouts.
// Record layouts are sized for the default 10-bit address / 18-bit data port.
package bram_port_pkg;

  // BRAM primitive read-latency modes
  localparam int LAT_LOW  = 1;  // LOW_LATENCY: dout straight from the array latch
  localparam int LAT_HIGH = 2;  // HIGH_PERFORMANCE: extra output register behind regce

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 18;

  // The response FIFO must hold every read in flight plus one slot so a
  // full pipe can keep streaming while the consumer pops.
  localparam int MIN_DEPTH_MARGIN = 1;

  function automatic bit lat_legal(int lat);
    return (lat == LAT_LOW) || (lat == LAT_HIGH);
  endfunction

  function automatic bit depth_legal(int depth, int lat);
    return (depth >= lat + MIN_DEPTH_MARGIN) && (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } bram_req_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
  } bram_resp_t;

endpackage

// File: rtl/bram_resp_fifo.sv
// Synchronous FIFO with first-word-fall-through read from storage and an
// occupancy count. Latency: a push is visible on pop_data/!empty the next cycle.
// Backpressure: none of its own; the caller guarantees no push when full.
// Ports: clock/reset_n; push/push_data write side; pop/pop_data/empty read
// side; count = current occupancy (0..DEPTH).
module bram_resp_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/bram_port_requester.sv
// Initiator for one BRAM port: forwards requests to the pins, tracks reads
// through the fixed read latency and parks returned data in a response FIFO.
// Latency: BRAM pins combinational from the request; read data resp_valid at
// t+READ_LATENCY+1. Backpressure: credit counter drops req_ready once
// RESP_DEPTH reads are in flight or queued, so no read data is ever lost.
// Ports: clock/reset_n; req_* request channel; resp_* response channel;
// bram_* pins to the BRAM port (bram_dout returns read data).
module bram_port_requester
  import bram_port_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 18,
  parameter int READ_LATENCY = LAT_HIGH,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  bram_en,
  output logic                  bram_regce,
  output logic                  bram_reset,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int CW        = $clog2(RESP_DEPTH + 1);
  localparam bit PARAMS_OK = lat_legal(READ_LATENCY) && depth_legal(RESP_DEPTH, READ_LATENCY);

  logic                    req_fire;
  logic                    rd_fire;
  logic                    resp_fire;
  logic [CW-1:0]           cnt;          // reads in flight + FIFO occupancy
  logic [READ_LATENCY-1:0] vld;          // vld[i]: a read issued i+1 cycles ago
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;

  // Gating with reset_n keeps the port quiet while reset is held, even
  // though cnt already reads zero.
  assign req_ready = reset_n && (cnt < CW'(RESP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_write;
  assign resp_fire = resp_valid && resp_ready;

  assign bram_en    = req_fire;
  assign bram_we    = req_fire && req_write;
  assign bram_addr  = req_addr;
  assign bram_din   = req_wdata;
  assign bram_reset = !reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + CW'(rd_fire) - CW'(resp_fire);
  end

  generate
    if (READ_LATENCY == LAT_HIGH) begin : g_lat_high
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld <= '0;
        else          vld <= {vld[0], rd_fire};
      end
      // Output register loads one cycle after the array read.
      assign bram_regce = vld[0];
    end else begin : g_lat_low
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld <= '0;
        else          vld <= rd_fire;
      end
      assign bram_regce = 1'b0;
    end
  endgenerate

  // Write cycles never set vld, so read-first old data on dout is ignored.
  bram_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (vld[READ_LATENCY-1]),
    .push_data (bram_dout),
    .pop       (resp_fire),
    .pop_data  (resp_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = !fifo_empty;

  a_params_ok:  assert property (@(posedge clock) PARAMS_OK);
  a_cnt_bound:  assert property (@(posedge clock) disable iff (!reset_n) cnt <= CW'(RESP_DEPTH));
  a_cnt_covers: assert property (@(posedge clock) disable iff (!reset_n) fifo_count <= cnt);

endmodule

// File: tb/tb_bram_port_requester.sv
// Bench: two requesters (HIGH_PERFORMANCE and LOW_LATENCY) share one stimulus
// stream, each paired with its own BRAM port model and transaction-level model.
module tb_bram_port_requester;
  import bram_port_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 4;
  localparam int NI    = 2;   // instance 0: latency 2, instance 1: latency 1

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  typedef struct { bram_req_t req; logic [DW-1:0] exp; } vec_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;

  logic          req_ready  [NI];
  logic          resp_valid [NI];
  logic [DW-1:0] resp_rdata [NI];
  logic [AW-1:0] bram_addr  [NI];
  logic [DW-1:0] bram_din   [NI];
  logic          bram_we    [NI];
  logic          bram_en    [NI];
  logic          bram_regce [NI];
  logic          bram_reset [NI];
  logic [DW-1:0] bram_dout  [NI];

  always #5 clock = ~clock;

  for (genvar k = 0; k < NI; k++) begin : g_inst
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] lat_q = '0;
    logic [DW-1:0] oreg_q = '0;

    bram_port_requester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .READ_LATENCY(k == 0 ? LAT_HIGH : LAT_LOW), .RESP_DEPTH(DEPTH)
    ) u_dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready[k]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[k]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[k]),
      .bram_addr(bram_addr[k]), .bram_din(bram_din[k]), .bram_we(bram_we[k]),
      .bram_en(bram_en[k]), .bram_regce(bram_regce[k]), .bram_reset(bram_reset[k]),
      .bram_dout(bram_dout[k])
    );

    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Read-first BRAM port: array latch, plus output register for latency 2.
    always @(posedge clock) begin
      if (bram_en[k]) begin
        lat_q <= mem[bram_addr[k]];
        if (bram_we[k]) mem[bram_addr[k]] <= bram_din[k];
      end
      if (bram_reset[k])      oreg_q <= '0;
      else if (bram_regce[k]) oreg_q <= lat_q;
    end
    assign bram_dout[k] = (k == 0) ? oreg_q : lat_q;
  end

  // Transaction-level model state
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [DW-1:0] mem_ref   [NI][1<<AW];
  exp_t          exp_q     [NI][$];
  logic [DW-1:0] got_q     [NI][$];
  int            got_cyc   [NI][$];
  logic [AW-1:0] rd_addr_q [NI][$];

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d: got=%0h want=%0h cyc=%0d", name, 2 - k, act, exp, cyc);
    end
  endtask

  task automatic chk1(string name, int k, logic act, logic exp);
    chk(name, k, 32'(act), 32'(exp));
  endtask

  // One clock cycle: compare outputs at the falling edge against the model,
  // advance the model by whatever fires this cycle, return just after the rise.
  task automatic tick();
    bit rdy_e, vld_e;
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      chk1("bram_reset", k, bram_reset[k], !reset_n);
      chk("bram_addr", k, 32'(bram_addr[k]), 32'(req_addr));
      chk("bram_din", k, 32'(bram_din[k]), 32'(req_wdata));
      if (!reset_n) begin
        exp_q[k].delete();
        rdy_e = 1'b0;
        vld_e = 1'b0;
      end else begin
        rdy_e = exp_q[k].size() < DEPTH;
        vld_e = (exp_q[k].size() > 0) && (exp_q[k][0].due <= cyc);
      end
      chk1("req_ready", k, req_ready[k], rdy_e);
      chk1("resp_valid", k, resp_valid[k], vld_e);
      chk1("bram_en", k, bram_en[k], req_valid && rdy_e);
      chk1("bram_we", k, bram_we[k], req_valid && rdy_e && req_write);
      if (vld_e && resp_ready) begin
        chk("resp_rdata", k, 32'(resp_rdata[k]), 32'(exp_q[k][0].data));
        got_q[k].push_back(resp_rdata[k]);
        got_cyc[k].push_back(cyc);
        void'(exp_q[k].pop_front());
      end
      if (req_valid && rdy_e) begin
        if (req_write) mem_ref[k][req_addr] = req_wdata;
        else begin
          exp_q[k].push_back('{data: mem_ref[k][req_addr], due: cyc + (2 - k) + 1});
          rd_addr_q[k].push_back(req_addr);
        end
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(bit wr, int a, int d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = AW'(a);
    req_wdata = DW'(d);
    tick();
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    req_write = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    for (int k = 0; k < NI; k++) begin
      got_q[k].delete();
      got_cyc[k].delete();
      rd_addr_q[k].delete();
    end
  endtask

  initial begin
    vec_t tbl [10];
    int   seen  [NI];
    int   drops [NI];
    int   acc   [NI];
    int   nrd;

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < (1 << AW); i++) mem_ref[k][i] = '0;

    tbl[0] = '{'{10'h007, 1'b1, 18'h000AA}, 18'h0};
    tbl[1] = '{'{10'h007, 1'b1, 18'h00111}, 18'h0};
    tbl[2] = '{'{10'h007, 1'b0, 18'h0},     18'h00111};
    tbl[3] = '{'{10'h3FF, 1'b1, 18'h3FFFF}, 18'h0};
    tbl[4] = '{'{10'h3FF, 1'b0, 18'h0},     18'h3FFFF};
    tbl[5] = '{'{10'h000, 1'b1, 18'h12345}, 18'h0};
    tbl[6] = '{'{10'h000, 1'b0, 18'h0},     18'h12345};
    tbl[7] = '{'{10'h005, 1'b0, 18'h0},     18'h002A5};
    tbl[8] = '{'{10'h005, 1'b1, 18'h00000}, 18'h0};
    tbl[9] = '{'{10'h005, 1'b0, 18'h0},     18'h00000};

    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    resp_ready = 1'b1;

    // Write then read: latency t+3 (latency 2) and t+2 (latency 1)
    clear_logs();
    issue(1, 5, 'h2A5);
    issue(0, 5, 0);
    req_valid = 1'b0;
    for (int k = 0; k < NI; k++) seen[k] = -1;
    for (int n = 1; n <= 6; n++) begin
      for (int k = 0; k < NI; k++) if (resp_valid[k] && seen[k] < 0) seen[k] = n;
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      chk("lat_cycles", k, 32'(seen[k]), 32'(3 - k));
      chk("lat_nresp", k, 32'(got_q[k].size()), 32'd1);
      if (got_q[k].size() > 0) chk("lat_rdata", k, 32'(got_q[k][0]), 32'h2A5);
    end

    // Table of back-to-back operations; writes must yield no response
    clear_logs();
    for (int i = 0; i < 10; i++) issue(tbl[i].req.write, int'(tbl[i].req.addr), int'(tbl[i].req.wdata));
    idle(6);
    for (int k = 0; k < NI; k++) begin
      nrd = 0;
      for (int i = 0; i < 10; i++) begin
        if (!tbl[i].req.write) begin
          if (got_q[k].size() > nrd) chk("tbl_rdata", k, 32'(got_q[k][nrd]), 32'(tbl[i].exp));
          nrd++;
        end
      end
      chk("tbl_nresp", k, 32'(got_q[k].size()), 32'(nrd));
    end

    // Streaming: preload addr*3, then 16 back-to-back reads
    for (int a = 0; a < 16; a++) issue(1, a, a * 3);
    idle(2);
    clear_logs();
    for (int k = 0; k < NI; k++) drops[k] = 0;
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < NI; k++) if (!req_ready[k]) drops[k]++;
      issue(0, a, 0);
    end
    idle(6);
    for (int k = 0; k < NI; k++) begin
      chk("stream_drops", k, 32'(drops[k]), 32'd0);
      chk("stream_nresp", k, 32'(got_q[k].size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
        if (got_q[k].size() > i) begin
          chk("stream_rdata", k, 32'(got_q[k][i]), 32'(i * 3));
          chk("stream_gap", k, 32'(got_cyc[k][i] - got_cyc[k][0]), 32'(i));
        end
      end
    end

    // Backpressure: exactly DEPTH reads accepted, then simultaneous push/pop
    clear_logs();
    resp_ready = 1'b0;
    for (int k = 0; k < NI; k++) acc[k] = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i);
      for (int k = 0; k < NI; k++) if (req_ready[k]) acc[k]++;
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      chk("bp_accepts", k, 32'(acc[k]), 32'(DEPTH));
      chk1("bp_ready_low", k, req_ready[k], 1'b0);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'($urandom_range(0, 15));
      tick();
    end
    idle(8);
    for (int k = 0; k < NI; k++) begin
      chk("bp_nresp", k, 32'(got_q[k].size()), 32'(rd_addr_q[k].size()));
      for (int i = 0; i < got_q[k].size() && i < rd_addr_q[k].size(); i++)
        chk("bp_order", k, 32'(got_q[k][i]), 32'(rd_addr_q[k][i]) * 3);
    end

    // Randomised mix of reads, writes and consumer stalls
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = ($urandom_range(0, 2) == 0);
      req_addr   = AW'($urandom_range(0, 31));
      req_wdata  = DW'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    resp_ready = 1'b1;
    idle(8);
    for (int k = 0; k < NI; k++) chk("rand_drained", k, 32'(exp_q[k].size()), 32'd0);

    // Asynchronous reset with reads both in flight and queued
    resp_ready = 1'b0;
    for (int a = 1; a <= 4; a++) issue(0, a, 0);
    req_valid = 1'b0;
    for (int k = 0; k < NI; k++) chk1("pre_arst_valid", k, resp_valid[k], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1("arst_valid", k, resp_valid[k], 1'b0);
      chk1("arst_bram_reset", k, bram_reset[k], 1'b1);
      chk1("arst_ready", k, req_ready[k], 1'b0);
    end
    idle(2);
    reset_n = 1'b1;
    resp_ready = 1'b1;
    clear_logs();
    idle(6);
    for (int k = 0; k < NI; k++) chk("no_stale", k, 32'(got_q[k].size()), 32'd0);
    for (int a = 1; a <= 4; a++) issue(0, a, 0);
    idle(6);
    for (int k = 0; k < NI; k++) begin
      chk("post_rst_nresp", k, 32'(got_q[k].size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q[k].size(); i++)
        chk("post_rst_rdata", k, 32'(got_q[k][i]), 32'(mem_ref[k][i + 1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
